// File: rtl/branch_mask_alloc.sv
// Branch-mask bit allocator: grants free checkpoint bits to dispatching branches and frees them on resolve or squash.
// Optional performance counters are compiled in when BMASK_PERF_EN is defined.
module branch_mask_alloc #(
  parameter int B_MASK_WIDTH   = 4,
  parameter int DISPATCH_WIDTH = 2,
  parameter int CNT_W          = 16
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [DISPATCH_WIDTH-1:0]              br_req,
  input  logic                                   resolve_valid,
  input  logic [B_MASK_WIDTH-1:0]                resolve_bmm,
  input  logic                                   resolve_mispred,
  output logic [DISPATCH_WIDTH*B_MASK_WIDTH-1:0] br_bit,
  output logic [DISPATCH_WIDTH*B_MASK_WIDTH-1:0] br_dep_mask,
  output logic [$clog2(DISPATCH_WIDTH+1)-1:0]    grant_cnt,
  output logic [B_MASK_WIDTH-1:0]                next_b_mask,
  output logic [B_MASK_WIDTH-1:0]                cur_b_mask,
  output logic [$clog2(B_MASK_WIDTH+1)-1:0]      free_cnt
`ifdef BMASK_PERF_EN
  ,
  output logic [CNT_W-1:0]                       perf_full_stall,
  output logic [CNT_W-1:0]                       perf_squash_bits
`endif
);

  localparam int W    = B_MASK_WIDTH;
  localparam int D    = DISPATCH_WIDTH;
  localparam int GC_W = $clog2(D + 1);
  localparam int FC_W = $clog2(W + 1);

  logic [W-1:0]    mask_reg;
  logic [W-1:0]    dep_reg     [W];
  logic [W-1:0]    dep_next    [W];
  logic [W-1:0]    dep_for_bit [W];
  logic [W-1:0]    slot_bit    [D];
  logic [W-1:0]    slot_bit_g  [D];
  logic [W-1:0]    slot_dep    [D];

  logic            mispred_now;
  logic            grant_en;
  logic [W-1:0]    clr_mask;
  logic [W-1:0]    dep_hit;
  logic [W-1:0]    kill_mask;
  logic [W-1:0]    surv_mask;
  logic [W-1:0]    surv_dep;
  logic [W-1:0]    avail;
  logic [W-1:0]    older_acc;
  logic [W-1:0]    granted_all;
  logic            walk_stop;
  logic            found;
  logic [GC_W-1:0] walk_cnt;
  logic [FC_W-1:0] free_cnt_c;

  assign mispred_now = resolve_valid & resolve_mispred;
  assign clr_mask    = resolve_valid ? resolve_bmm : '0;

  // A mispredict also squashes every in-flight branch that was younger than it.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_hit
      assign dep_hit[gi] = |(dep_reg[gi] & resolve_bmm);
    end
  endgenerate

  assign kill_mask = clr_mask | (mispred_now ? dep_hit : '0);
  assign surv_mask = mask_reg & ~kill_mask;
  assign surv_dep  = surv_mask & ~clr_mask;
  assign grant_en  = reset & ~mispred_now;

  // Only bits free at the start of the cycle are handed out; same-cycle frees wait a cycle.
  always_comb begin
    avail     = ~mask_reg;
    walk_stop = 1'b0;
    walk_cnt  = GC_W'(D);
    found     = 1'b0;
    for (int i = 0; i < D; i++) begin
      slot_bit[i] = '0;
      found       = 1'b0;
      if (br_req[i] && !walk_stop) begin
        for (int j = 0; j < W; j++) begin
          if (avail[j] && !found) begin
            slot_bit[i][j] = 1'b1;
            found          = 1'b1;
          end
        end
        if (found) begin
          avail = avail & ~slot_bit[i];
        end else begin
          walk_stop = 1'b1;
          walk_cnt  = GC_W'(i);
        end
      end
    end
  end

  always_comb begin
    older_acc = '0;
    for (int i = 0; i < D; i++) begin
      slot_bit_g[i] = grant_en ? slot_bit[i] : '0;
      slot_dep[i]   = (slot_bit_g[i] != '0) ? (surv_dep | older_acc) : '0;
      older_acc     = older_acc | slot_bit_g[i];
    end
    granted_all = older_acc;
    for (int j = 0; j < W; j++) begin
      dep_for_bit[j] = '0;
    end
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < W; j++) begin
        if (slot_bit_g[i][j]) begin
          dep_for_bit[j] = slot_dep[i];
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < W; j++) begin
      if (granted_all[j]) begin
        dep_next[j] = dep_for_bit[j];
      end else if (kill_mask[j]) begin
        dep_next[j] = '0;
      end else begin
        dep_next[j] = dep_reg[j] & ~clr_mask;
      end
    end
  end

  always_comb begin
    free_cnt_c = '0;
    for (int j = 0; j < W; j++) begin
      if (!mask_reg[j]) begin
        free_cnt_c = free_cnt_c + FC_W'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_slot
      assign br_bit[gi*W +: W]      = slot_bit_g[gi];
      assign br_dep_mask[gi*W +: W] = slot_dep[gi];
    end
  endgenerate

  assign grant_cnt   = mispred_now ? '0 : walk_cnt;
  assign next_b_mask = reset ? (surv_mask | granted_all) : '0;
  assign cur_b_mask  = mask_reg;
  assign free_cnt    = free_cnt_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_reg <= '0;
      for (int j = 0; j < W; j++) begin
        dep_reg[j] <= '0;
      end
    end else begin
      mask_reg <= next_b_mask;
      for (int j = 0; j < W; j++) begin
        dep_reg[j] <= dep_next[j];
      end
    end
  end

`ifdef BMASK_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] squash_cnt_reg;
  logic [FC_W-1:0]  kill_pop;
  logic [CNT_W:0]   squash_sum;

  always_comb begin
    kill_pop = '0;
    for (int j = 0; j < W; j++) begin
      if (kill_mask[j]) begin
        kill_pop = kill_pop + FC_W'(1);
      end
    end
  end

  assign squash_sum = {1'b0, squash_cnt_reg} + (CNT_W + 1)'(kill_pop);

  // A flush-suppressed grant is not an exhaustion stall, so mispredict cycles are excluded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg  <= '0;
      squash_cnt_reg <= '0;
    end else begin
      if (walk_stop && !mispred_now && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (mispred_now) begin
        squash_cnt_reg <= squash_sum[CNT_W] ? '1 : squash_sum[CNT_W-1:0];
      end
    end
  end

  assign perf_full_stall  = stall_cnt_reg;
  assign perf_squash_bits = squash_cnt_reg;
`endif

endmodule

// File: doc/branch_mask_alloc.md
Name: branch_mask_alloc

Overview:
- Dispatch-side allocator for branch-mask (B_MASK) bits. Sits directly upstream of the branch stack.
- Each cycle it picks free mask bits for up to DISPATCH_WIDTH dispatching branches and gives each one its one-hot bit and its dependency mask.
- It drives next_b_mask into the branch stack and frees bits when branches resolve, including the bits of younger branches squashed by a mispredict.
- Dispatch uses its grant count to stall.

Parameters:
B_MASK_WIDTH, 4, number of in-flight branch checkpoints (mask bits).
DISPATCH_WIDTH, 2, instruction slots per dispatch cycle.
CNT_W, 16, width of performance counters (used only under the optional feature).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
br_req  in  DISPATCH_WIDTH  slot i is a valid branch/jump needing a mask bit; slot 0 is oldest.
resolve_valid  in  1  a branch resolves this cycle.
resolve_bmm  in  B_MASK_WIDTH  one-hot bit of the resolving branch.
resolve_mispred  in  1  the resolving branch mispredicted (qualified by resolve_valid).
br_bit  out  DISPATCH_WIDTH*B_MASK_WIDTH  one-hot allocated bit per slot; zero if the slot was not granted.
br_dep_mask  out  DISPATCH_WIDTH*B_MASK_WIDTH  older in-flight bits slot i depends on; goes to the branch stack entry b_m.
grant_cnt  out  $clog2(DISPATCH_WIDTH+1)  number of leading slots dispatch may send this cycle.
next_b_mask  out  B_MASK_WIDTH  in-flight mask after this cycle's frees and grants; goes to the branch stack.
cur_b_mask  out  B_MASK_WIDTH  registered in-flight mask.
free_cnt  out  $clog2(B_MASK_WIDTH+1)  popcount(~cur_b_mask).

Behaviour:
- State:
  - mask_reg[B_MASK_WIDTH].
  - dep_reg[j][B_MASK_WIDTH]: the older bits branch j depends on.
- Reset (reset==0, asynchronous): mask_reg=0 and all dep_reg=0. Resulting outputs: cur_b_mask=0, free_cnt=B_MASK_WIDTH, next_b_mask=0, br_bit=0, br_dep_mask=0.
- grant_cnt is computed combinationally from br_req, even during reset.
- Kill set K:
  - Correct resolve: K = resolve_bmm.
  - Mispredict: K = resolve_bmm | {j : dep_reg[j] & resolve_bmm != 0}.
  - No resolve: K = 0.
- Survivor mask: S = mask_reg & ~K.
- Allocation:
  - Walk slots 0..DISPATCH_WIDTH-1 in order.
  - Each requesting slot takes the lowest-index bit of ~mask_reg not yet taken this cycle.
  - Bits freed this cycle (K) are NOT reusable until the next cycle.
  - Non-branch slots always pass.
  - The first branch slot with no bit available stops the walk. grant_cnt = index of that slot, else DISPATCH_WIDTH.
- Dependency of a granted slot i: (S, with resolve_bmm cleared) | bits granted to older slots this cycle.
- Mispredict in the same cycle (resolve_valid & resolve_mispred):
  - All grants are suppressed: br_bit=0 and grant_cnt=0, because dispatch is being flushed.
  - next_b_mask = S.
- Otherwise next_b_mask = S | granted bits.
- Register update (posedge):
  - mask_reg <= next_b_mask.
  - For every surviving j: dep_reg[j] &= ~resolve_bmm.
  - For killed j: dep_reg[j] <= 0.
  - For granted j: dep_reg[j] <= its computed dependency.
- Latency: br_bit, br_dep_mask, grant_cnt and next_b_mask are combinational in the same cycle. cur_b_mask and free_cnt reflect the grant one cycle later.
- Protocol errors (ignored; assertions in the bench):
  - resolve_bmm not one-hot when resolve_valid=1.
  - resolve_bmm naming a bit not set in mask_reg.
- Full (mask_reg all ones): grant_cnt = index of the first branch slot. No bits are granted even if a resolve frees one this cycle.

Optional Feature:
- Macro: BMASK_PERF_EN.
- When defined, adds outputs perf_full_stall (CNT_W) and perf_squash_bits (CNT_W). They saturate at all-ones and are cleared by reset.
  - perf_full_stall counts cycles where grant_cnt < DISPATCH_WIDTH because of bit exhaustion.
  - perf_squash_bits accumulates popcount(K) on mispredict cycles.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset, then br_req=2'b11 -> br_bit slot0=0001, slot1=0010; br_dep_mask slot0=0000, slot1=0001; grant_cnt=2; next cycle cur_b_mask=0011.
- Fill to 1111, then br_req=2'b01 -> grant_cnt=0, br_bit=0. Same cycle correct resolve of 0100 -> grant_cnt still 0; next cycle cur_b_mask=1011 and a retry is granted bit 0100.
- Chain 0001<-0010<-0100 (each depending on all older). Mispredict resolve_bmm=0010 -> K=0110, next_b_mask=0001, dep_reg of bit0 stays 0000.
- Correct resolve of 0001 with 0010 and 0100 in flight -> their dep_reg lose bit 0 (0000 and 0010); cur_b_mask=0110.
- Mispredict and br_req=2'b11 in the same cycle -> grant_cnt=0, no new bits appear in next_b_mask.
- Async reset asserted mid-cycle with cur_b_mask=1011 -> immediately 0 without waiting for a clock edge. With BMASK_PERF_EN defined, perf counters also read 0.
